// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin N-to-1 CBus arbiter; the grant is held from request to the last response beat.
package cbus_pkg;
  localparam logic [3:0] MLEN1 = 4'd0;
  localparam logic [3:0] MLEN2 = 4'd1;
  localparam logic [3:0] MLEN4 = 4'd3;
  localparam logic [3:0] MLEN8 = 4'd7;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] sel_q, sel_d, last_sel_q, last_sel_d, pick;
  logic             found;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      busy_q     <= 1'b0;
      sel_q      <= '0;
      last_sel_q <= IDX_W'(NUM_INPUTS - 1);
    end else begin
      busy_q     <= busy_d;
      sel_q      <= sel_d;
      last_sel_q <= last_sel_d;
    end

  // scan downward so the candidate closest after last_sel is the one kept
  always_comb begin
    found = 1'b0;
    pick  = sel_q;
    for (int i = NUM_INPUTS; i >= 1; i--) begin : scan
      logic [IDX_W-1:0] c;
      c = IDX_W'((int'(last_sel_q) + i) % NUM_INPUTS);
      if (ireqs[c].valid) begin
        found = 1'b1;
        pick  = c;
      end
    end
    busy_d     = busy_q ? !(oresp.ready && oresp.last) : found;
    sel_d      = (!busy_q && found) ? pick : sel_q;
    last_sel_d = (busy_q && oresp.ready && oresp.last) ? sel_q : last_sel_q;
  end

  always_comb begin
    oreq = busy_q ? ireqs[sel_q] : '0;
    for (int j = 0; j < NUM_INPUTS; j++)
      iresps[j] = (busy_q && sel_q == IDX_W'(j)) ? oresp : '0;
  end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed checks of grant, hold, routing, reset and fairness for 2- and 4-port arbiters.
module tb_cbus_arbiter;
  import cbus_pkg::*;
  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  r2 [2];
  cbus_resp_t p2 [2];
  cbus_req_t  o2;
  cbus_resp_t s2;
  cbus_req_t  r4 [4];
  cbus_resp_t p4 [4];
  cbus_req_t  o4;
  cbus_resp_t s4;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_INPUTS(2)) u2 (.clk(clk), .resetn(resetn), .ireqs(r2), .iresps(p2), .oreq(o2), .oresp(s2));
  cbus_arbiter #(.NUM_INPUTS(4)) u4 (.clk(clk), .resetn(resetn), .ireqs(r4), .iresps(p4), .oreq(o4), .oresp(s4));

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic cbus_req_t mk(input logic [31:0] a, input logic [3:0] l);
    cbus_req_t r;
    r = '0;
    r.valid = 1'b1;
    r.addr  = a;
    r.len   = l;
    return r;
  endfunction

  function automatic cbus_resp_t rs(input logic rdy, input logic lst, input logic [31:0] d);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.data  = d;
    return r;
  endfunction

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) r2[i] = '0;
    for (int i = 0; i < 4; i++) r4[i] = '0;
    s2 = '0;
    s4 = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(u2.busy_q), 64'd0);
    chk("rst_sel", 64'(u2.sel_q), 64'd0);
    chk("rst_last_sel", 64'(u2.last_sel_q), 64'd1);
    chk("rst_last_sel4", 64'(u4.last_sel_q), 64'd3);
    chk("rst_oreq", 64'(o2.valid), 64'd0);
    resetn = 1'b1;
    // single request
    r2[0] = mk(32'h8000_0000, MLEN1);
    #1;
    chk("t1_no_comb_grant", 64'(o2.valid), 64'd0);
    tick();
    chk("t1_grant_valid", 64'(o2.valid), 64'd1);
    chk("t1_grant_addr", 64'(o2.addr), 64'h8000_0000);
    chk("t1_sel", 64'(u2.sel_q), 64'd0);
    tick();
    chk("t1_wait_ready", 64'(p2[0].ready), 64'd0);
    s2 = rs(1'b1, 1'b1, 32'hDEAD_BEEF);
    #1;
    chk("t1_resp0", 64'(p2[0]), 64'(rs(1'b1, 1'b1, 32'hDEAD_BEEF)));
    chk("t1_resp1_zero", 64'(p2[1]), 64'd0);
    tick();
    r2[0] = '0;
    s2 = '0;
    #1;
    chk("t1_busy_after", 64'(u2.busy_q), 64'd0);
    chk("t1_last_sel", 64'(u2.last_sel_q), 64'd0);
    chk("t1_oreq_idle", 64'(o2), 64'd0);
    // simultaneous requests after a fresh reset
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    r2[0] = mk(32'h100, MLEN1);
    r2[1] = mk(32'h200, MLEN1);
    tick();
    chk("t2_first_sel", 64'(u2.sel_q), 64'd0);
    chk("t2_first_addr", 64'(o2.addr), 64'h100);
    s2 = rs(1'b1, 1'b1, 32'h1111);
    #1;
    chk("t2_resp0", 64'(p2[0].data), 64'h1111);
    chk("t2_resp1_blocked", 64'(p2[1]), 64'd0);
    tick();
    s2 = '0;
    #1;
    chk("t2_bubble", 64'(u2.busy_q), 64'd0);
    chk("t2_bubble_oreq", 64'(o2.valid), 64'd0);
    tick();
    chk("t2_second_sel", 64'(u2.sel_q), 64'd1);
    chk("t2_second_addr", 64'(o2.addr), 64'h200);
    s2 = rs(1'b1, 1'b1, 32'h2222);
    #1;
    chk("t2_resp1", 64'(p2[1].data), 64'h2222);
    chk("t2_resp0_blocked", 64'(p2[0]), 64'd0);
    tick();
    s2 = '0;
    r2[1] = '0;
    tick();
    chk("t2_third_sel", 64'(u2.sel_q), 64'd0);
    chk("t2_third_busy", 64'(u2.busy_q), 64'd1);
    s2 = rs(1'b1, 1'b1, 32'h3333);
    tick();
    r2[0] = '0;
    s2 = '0;
    // burst hold on port 1 while port 0 arrives
    r2[1] = mk(32'h1000, MLEN4);
    tick();
    chk("t3_sel", 64'(u2.sel_q), 64'd1);
    for (int b = 1; b <= 4; b++) begin
      s2 = rs(1'b1, b == 4, 32'hA0 + 32'(b));
      if (b == 2) r2[0] = mk(32'h2000, MLEN1);
      #1;
      chk($sformatf("t3_addr_beat%0d", b), 64'(o2.addr), 64'h1000);
      chk($sformatf("t3_sel_beat%0d", b), 64'(u2.sel_q), 64'd1);
      chk($sformatf("t3_data_beat%0d", b), 64'(p2[1].data), 64'hA0 + 64'(b));
      tick();
    end
    r2[1] = '0;
    s2 = '0;
    #1;
    chk("t3_bubble", 64'(u2.busy_q), 64'd0);
    tick();
    chk("t3_port0_sel", 64'(u2.sel_q), 64'd0);
    chk("t3_port0_addr", 64'(o2.addr), 64'h2000);
    s2 = rs(1'b1, 1'b1, 32'h0);
    tick();
    r2[0] = '0;
    s2 = '0;
    // reset in the middle of a burst
    r2[0] = mk(32'h3000, MLEN4);
    r2[1] = mk(32'h4000, MLEN4);
    tick();
    chk("t4_sel", 64'(u2.sel_q), 64'd1);
    s2 = rs(1'b1, 1'b0, 32'h55);
    tick();
    tick();
    resetn = 1'b0;
    s2 = '0;
    #1;
    chk("t4_oreq_valid", 64'(o2.valid), 64'd0);
    chk("t4_resp0", 64'(p2[0]), 64'd0);
    chk("t4_resp1", 64'(p2[1]), 64'd0);
    chk("t4_busy", 64'(u2.busy_q), 64'd0);
    chk("t4_last_sel", 64'(u2.last_sel_q), 64'd1);
    tick();
    resetn = 1'b1;
    tick();
    chk("t4_tie_sel", 64'(u2.sel_q), 64'd0);
    chk("t4_tie_busy", 64'(u2.busy_q), 64'd1);
    s2 = rs(1'b1, 1'b1, 32'h0);
    tick();
    r2[0] = '0;
    r2[1] = '0;
    s2 = '0;
    tick();
    // response activity while idle
    s2 = rs(1'b1, 1'b1, 32'hFFFF_FFFF);
    #1;
    chk("t5_resp0", 64'(p2[0]), 64'd0);
    chk("t5_resp1", 64'(p2[1]), 64'd0);
    tick();
    chk("t5_busy", 64'(u2.busy_q), 64'd0);
    tick();
    chk("t5_busy2", 64'(u2.busy_q), 64'd0);
    s2 = '0;
    // four-port rotation with single-beat transactions
    for (int i = 0; i < 4; i++) r4[i] = mk(32'h10 * 32'(i), MLEN1);
    s4 = rs(1'b1, 1'b1, 32'h77);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t6_busy_g%0d", k), 64'(u4.busy_q), 64'd1);
      chk($sformatf("t6_sel_g%0d", k), 64'(u4.sel_q), 64'(k % 4));
      chk($sformatf("t6_addr_g%0d", k), 64'(o4.addr), 64'h10 * 64'(k % 4));
      tick();
      chk($sformatf("t6_bubble_g%0d", k), 64'(u4.busy_q), 64'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- N-to-1 arbiter between master-side CBus ports (D-side bridge, I-side bridge, uncached paths) and the single CBus toward the memory/AXI adapter.
- Sits directly downstream of the DBus-to-CBus converter and consumes its CBus request.
- Grants one master at a time, round-robin, and holds the grant for the whole transaction, through the beat with `last`.
- Routes the shared response only to the granted master.

Parameters:
- NUM_INPUTS, 2, number of master CBus ports (2..8).
- IDX_W, $clog2(NUM_INPUTS), width of the grant index (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- ireqs  input  cbus_req_t[NUM_INPUTS]  master requests; index 0 = D-side, 1 = I-side.
- iresps  output  cbus_resp_t[NUM_INPUTS]  per-master responses.
- oreq  output  cbus_req_t  request to the memory side.
- oresp  input  cbus_resp_t  response from the memory side.

Behaviour:
- State: busy (1b), sel (IDX_W), last_sel (IDX_W). All are cleared asynchronously when resetn = 0, giving busy = 0, sel = 0, last_sel = NUM_INPUTS-1.
- IDLE (busy = 0):
  - oreq is all-zero, including valid = 0.
  - Every iresps[i] is all-zero.
  - Scan for valid masters starting at (last_sel+1) mod NUM_INPUTS and wrapping round.
  - First valid master found: sel <= that index, busy <= 1 at the next edge.
  - No valid master: hold IDLE.
- Grant latency: 1 cycle from ireqs[k].valid rising (while IDLE) to oreq.valid = 1. Arbitration is registered; there is no combinational path from ireqs.valid to the grant decision.
- BUSY (busy = 1):
  - oreq = ireqs[sel], all fields passed through combinationally.
  - iresps[sel] = oresp.
  - iresps[j], j != sel: ready = 0, last = 0, data = 0.
- End of transaction: when busy && oresp.ready && oresp.last at a rising edge:
  - busy <= 0, last_sel <= sel.
  - The next grant is decided in the following IDLE cycle, so there is a 1-cycle bubble between back-to-back transactions.
- Multi-beat bursts (len > MLEN1): the grant is held across every beat where oresp.ready = 1 and last = 0. Only the `last` handshake releases it.
- Fairness:
  - With all masters continuously valid, grants rotate 0,1,…,N-1,0.
  - No master waits more than N-1 transactions.
- Master protocol: a master holds its request stable and valid from the grant until last. If ireqs[sel].valid drops mid-transaction, the arbiter does not release; it keeps forwarding (oreq.valid = 0) until oresp last.
- oresp.ready while IDLE is ignored and is not forwarded.
- Reset asserted mid-transaction:
  - Outputs return to IDLE values immediately, asynchronously.
  - The pending transaction is dropped; the downstream adapter is reset by the same resetn.
- A new request arriving on another port while BUSY only waits; it causes no change to oreq.

Test Plan:
- Reset then single request: resetn low 3 cycles, then high. ireqs[0] = {valid = 1, is_write = 0, addr = 0x8000_0000, len = MLEN1}, memory answers ready+last with data = 0xDEAD_BEEF 2 cycles after oreq.valid. Required:
  - oreq.valid rises 1 cycle after the request.
  - iresps[0].data = 0xDEAD_BEEF with ready = last = 1.
  - iresps[1] stays all-zero.
  - busy = 0 the next cycle.
- Simultaneous requests: ireqs[0] and ireqs[1] valid at the same edge after reset (last_sel = 1). Required:
  - Port 0 is granted first.
  - Port 1 is granted 1 cycle after port 0's last beat.
  - Then port 0 again if it is still valid.
- Burst hold: port 1 issues len = MLEN4 at addr 0x1000, memory returns 4 beats with last on beat 4, and port 0 is asserted during beat 2. Required:
  - oreq.addr stays 0x1000 through all 4 beats.
  - Port 0 is granted only after beat 4.
- Mid-transaction reset: resetn pulled low between beats 2 and 3 of a MLEN4 burst. Required:
  - oreq.valid = 0 and all iresps zero in the same cycle.
  - After release, last_sel = NUM_INPUTS-1, so port 0 wins the tie.
- Idle ready glitch: oresp.ready = 1, last = 1 while no request is pending. Required:
  - All iresps remain zero.
  - busy stays 0.
- Fairness with NUM_INPUTS = 4: all four ports continuously valid, each transaction 1 beat. Required: grant order 0,1,2,3,0,1, with exactly one bubble cycle between grants.
